// File: rtl/fft_pkg.sv
// fft_pkg: constants, bin-index helper and read FSM state type shared by the
// 512-point, 16-lane FFT output reorder logic.
package fft_pkg;

    localparam int FFT_N            = 512;
    localparam int LANES            = 16;
    localparam int CYCLES_PER_FRAME = FFT_N / LANES;
    localparam int LOG2_N           = 9;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } read_state_e;

    // Mirror a 9-bit sample position into the bin it carries.
    function automatic logic [LOG2_N-1:0] bitrev9(input logic [LOG2_N-1:0] k);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = k[LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: 16-lane complex sample stream into and out of the
// reorder buffer. The producer/consumer side uses master, the buffer slave.
interface fft_out_reorder_if #(
    parameter int DATA_WIDTH = 13,
    parameter int LANES      = 16
);

    logic                         din_valid;
    logic signed [DATA_WIDTH-1:0] din_r [LANES];
    logic signed [DATA_WIDTH-1:0] din_i [LANES];
    logic                         dout_valid;
    logic                         dout_sof;
    logic signed [DATA_WIDTH-1:0] dout_r [LANES];
    logic signed [DATA_WIDTH-1:0] dout_i [LANES];

    modport master (
        output din_valid, din_r, din_i,
        input  dout_valid, dout_sof, dout_r, dout_i
    );

    modport slave (
        input  din_valid, din_r, din_i,
        output dout_valid, dout_sof, dout_r, dout_i
    );

endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame of storage. Writes scatter each lane to its
// bit-reversed bin address; reads return 16 consecutive bins combinationally.
module fft_reorder_bank #(
    parameter int DATA_WIDTH = 13,
    parameter int LANES      = 16,
    parameter int FFT_N      = 512,
    parameter int CNT_W      = $clog2(FFT_N / LANES)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [CNT_W-1:0]             wr_beat,
    input  logic signed [DATA_WIDTH-1:0] wr_r [LANES],
    input  logic signed [DATA_WIDTH-1:0] wr_i [LANES],
    input  logic [CNT_W-1:0]             rd_row,
    output logic signed [DATA_WIDTH-1:0] rd_r [LANES],
    output logic signed [DATA_WIDTH-1:0] rd_i [LANES]
);
    import fft_pkg::*;

    localparam int LANE_W = $clog2(LANES);

    logic signed [DATA_WIDTH-1:0] mem_r [FFT_N];
    logic signed [DATA_WIDTH-1:0] mem_i [FFT_N];

    // Scatter every lane of an accepted beat to the bin it holds
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                mem_r[bitrev9({wr_beat, LANE_W'(l)})] <= wr_r[l];
                mem_i[bitrev9({wr_beat, LANE_W'(l)})] <= wr_i[l];
            end
        end
    end

    // Present bins rd_row*LANES .. rd_row*LANES+LANES-1 in natural order
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rd_r[l] = mem_r[{rd_row, LANE_W'(l)}];
            rd_i[l] = mem_i[{rd_row, LANE_W'(l)}];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong reorder buffer turning bit-reversed FFT output
// beats into natural bin order, 16 bins per clock, with registered outputs.
module fft_out_reorder #(
    parameter int DATA_WIDTH = 13,
    parameter int LANES      = 16,
    parameter int FFT_N      = 512
) (
    input  logic             clk,
    input  logic             rst,
    fft_out_reorder_if.slave io
);
    import fft_pkg::*;

    localparam int               CNT_W     = $clog2(FFT_N / LANES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_N / LANES - 1);

    logic [CNT_W-1:0]             wr_cnt;
    logic                         wr_bank;
    logic [1:0]                   bank_full;
    read_state_e                  rd_state;
    logic                         rd_bank;
    logic [CNT_W-1:0]             rd_cnt;
    logic [CNT_W-1:0]             rd_row;
    logic                         rd_emit;
    logic                         we0;
    logic                         we1;
    logic signed [DATA_WIDTH-1:0] in_r  [LANES];
    logic signed [DATA_WIDTH-1:0] in_i  [LANES];
    logic signed [DATA_WIDTH-1:0] b0_r  [LANES];
    logic signed [DATA_WIDTH-1:0] b0_i  [LANES];
    logic signed [DATA_WIDTH-1:0] b1_r  [LANES];
    logic signed [DATA_WIDTH-1:0] b1_i  [LANES];
    logic signed [DATA_WIDTH-1:0] sel_r [LANES];
    logic signed [DATA_WIDTH-1:0] sel_i [LANES];

    // Route the incoming beat to the bank currently being filled
    always_comb begin
        we0 = io.din_valid && !wr_bank;
        we1 = io.din_valid && wr_bank;
        for (int l = 0; l < LANES; l++) begin
            in_r[l] = io.din_r[l];
            in_i[l] = io.din_i[l];
        end
    end

    fft_reorder_bank #(
        .DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .FFT_N(FFT_N), .CNT_W(CNT_W)
    ) u_bank0 (
        .clk(clk), .we(we0), .wr_beat(wr_cnt), .wr_r(in_r), .wr_i(in_i),
        .rd_row(rd_row), .rd_r(b0_r), .rd_i(b0_i)
    );

    fft_reorder_bank #(
        .DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .FFT_N(FFT_N), .CNT_W(CNT_W)
    ) u_bank1 (
        .clk(clk), .we(we1), .wr_beat(wr_cnt), .wr_r(in_r), .wr_i(in_i),
        .rd_row(rd_row), .rd_r(b1_r), .rd_i(b1_i)
    );

    // Pick the row to emit; IDLE emits row 0 of a full bank on the very edge
    // it starts the read, so the first output follows the last write by one clock
    always_comb begin
        rd_emit = (rd_state == READ) || bank_full[rd_bank];
        rd_row  = (rd_state == READ) ? rd_cnt : '0;
        for (int l = 0; l < LANES; l++) begin
            sel_r[l] = rd_bank ? b1_r[l] : b0_r[l];
            sel_i[l] = rd_bank ? b1_i[l] : b0_i[l];
        end
    end

    // Write counter, bank status flags and read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            rd_state  <= IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
        end else begin
            // Release first; the writer only ever completes the other bank
            if (rd_state == READ && rd_cnt == LAST_BEAT) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (io.din_valid) begin
                if (wr_cnt == LAST_BEAT) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                    wr_cnt             <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // Frames alternate banks, so rd_bank always names the next bank to drain
            case (rd_state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state <= READ;
                        rd_cnt   <= CNT_W'(1);
                    end
                end
                READ: begin
                    if (rd_cnt == LAST_BEAT) begin
                        rd_bank  <= ~rd_bank;
                        rd_cnt   <= '0;
                        rd_state <= bank_full[~rd_bank] ? READ : IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

    // Register the selected row onto the output lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.dout_valid <= 1'b0;
            io.dout_sof   <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                io.dout_r[l] <= '0;
                io.dout_i[l] <= '0;
            end
        end else begin
            io.dout_valid <= rd_emit;
            io.dout_sof   <= rd_emit && (rd_row == '0);
            if (rd_emit) begin
                for (int l = 0; l < LANES; l++) begin
                    io.dout_r[l] <= sel_r[l];
                    io.dout_i[l] <= sel_i[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed sequence with random data for the FFT output
// reorder buffer, checked against a bin-indexed frame model.
module tb_fft_out_reorder;

    localparam int DW    = 13;
    localparam int NL    = 16;
    localparam int NPT   = 512;
    localparam int BEATS = NPT / NL;
    localparam int W     = DW * NL;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    // Frame model: value of each bin, natural order
    int fr [NPT];
    int fi [NPT];

    logic [W-1:0] exp_r [$];
    logic [W-1:0] exp_i [$];
    logic [W-1:0] cap_r [$];
    logic [W-1:0] cap_i [$];
    bit           cap_sof [$];
    int           cap_cyc [$];
    int           lastacc_q [$];

    fft_out_reorder_if #(.DATA_WIDTH(DW), .LANES(NL)) bus ();

    fft_out_reorder #(.DATA_WIDTH(DW), .LANES(NL), .FFT_N(NPT)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack_out(input bit imag);
        logic [W-1:0] v;
        for (int l = 0; l < NL; l++) begin
            v[l*DW +: DW] = imag ? bus.dout_i[l] : bus.dout_r[l];
        end
        return v;
    endfunction

    // Output monitor
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            cap_r.push_back(pack_out(1'b0));
            cap_i.push_back(pack_out(1'b1));
            cap_sof.push_back(bus.dout_sof);
            cap_cyc.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int brev9(input int k);
        int r = 0;
        for (int i = 0; i < 9; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic gen_ramp(input int off);
        for (int b = 0; b < NPT; b++) begin
            fr[b] = b + off;
            fi[b] = -(b + off);
        end
    endtask

    task automatic gen_const(input int v);
        for (int b = 0; b < NPT; b++) begin
            fr[b] = v;
            fi[b] = v;
        end
    endtask

    task automatic gen_rand();
        for (int b = 0; b < NPT; b++) begin
            fr[b] = int'($urandom_range(8191)) - 4096;
            fi[b] = int'($urandom_range(8191)) - 4096;
        end
    endtask

    function automatic bit is_gap(input int mode, input int t);
        if (mode == 1) return (t % 3) == 2;
        if (mode == 2) return $urandom_range(3) == 0;
        return 1'b0;
    endfunction

    // Drive nbeats beats in bit-reversed order; valid is left high at the end
    task automatic drive_frame(input int nbeats, input int gap);
        int           t = 0;
        logic [W-1:0] vr;
        logic [W-1:0] vi;
        for (int c = 0; c < nbeats; c++) begin
            @(negedge clk);
            while (is_gap(gap, t)) begin
                bus.din_valid = 1'b0;
                t++;
                @(negedge clk);
            end
            bus.din_valid = 1'b1;
            for (int l = 0; l < NL; l++) begin
                bus.din_r[l] = DW'(fr[brev9(c * NL + l)]);
                bus.din_i[l] = DW'(fi[brev9(c * NL + l)]);
            end
            t++;
        end
        if (nbeats == BEATS) begin
            lastacc_q.push_back(cyc + 1);
            for (int c = 0; c < BEATS; c++) begin
                for (int l = 0; l < NL; l++) begin
                    vr[l*DW +: DW] = DW'(fr[c * NL + l]);
                    vi[l*DW +: DW] = DW'(fi[c * NL + l]);
                end
                exp_r.push_back(vr);
                exp_i.push_back(vi);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic clear_queues();
        cap_r.delete(); cap_i.delete(); cap_sof.delete(); cap_cyc.delete();
        exp_r.delete(); exp_i.delete(); lastacc_q.delete();
    endtask

    // Wait (bounded) for n beats, then compare the captured stream to the model
    task automatic check_stream(input string tag, input int n);
        int m;
        for (int t = 0; t < n + 100 && cap_r.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_beats"}, W'(cap_r.size()), W'(n));
        if (cap_r.size() > 0 && lastacc_q.size() > 0)
            check({tag, "_latency"}, W'(cap_cyc[0]), W'(lastacc_q[0] + 1));
        m = (cap_r.size() < exp_r.size()) ? cap_r.size() : exp_r.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_cont%0d", tag, i), W'(cap_cyc[i]),
                  W'(cap_cyc[i - (i % BEATS)] + (i % BEATS)));
            check($sformatf("%s_sof%0d", tag, i), W'(cap_sof[i]), W'((i % BEATS) == 0));
            check($sformatf("%s_re%0d", tag, i), cap_r[i], exp_r[i]);
            check($sformatf("%s_im%0d", tag, i), cap_i[i], exp_i[i]);
        end
        clear_queues();
    endtask

    initial begin
        rst = 1'b1;
        bus.din_valid = 1'b0;
        for (int l = 0; l < NL; l++) begin
            bus.din_r[l] = '0;
            bus.din_i[l] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_valid", W'(bus.dout_valid), W'(0));
        check("reset_sof", W'(bus.dout_sof), W'(0));
        check("reset_re", pack_out(1'b0), W'(0));
        check("reset_im", pack_out(1'b1), W'(0));
        rst = 1'b0;

        // Single contiguous frame: bin value b, -b
        gen_ramp(0);
        drive_frame(BEATS, 0);
        go_idle();
        check_stream("single", BEATS);

        // Same frame, din_valid low every third cycle
        gen_ramp(0);
        drive_frame(BEATS, 1);
        go_idle();
        check_stream("gapped", BEATS);

        // Three back-to-back frames with offsets 0, +1000, -1000
        gen_ramp(0);
        drive_frame(BEATS, 0);
        gen_ramp(1000);
        drive_frame(BEATS, 0);
        gen_ramp(-1000);
        drive_frame(BEATS, 0);
        go_idle();
        check_stream("b2b", 3 * BEATS);

        // Full-scale extremes
        gen_const(4095);
        drive_frame(BEATS, 0);
        gen_const(-4096);
        drive_frame(BEATS, 0);
        go_idle();
        check_stream("extreme", 2 * BEATS);

        // Random data with random gaps
        gen_rand();
        drive_frame(BEATS, 2);
        gen_rand();
        drive_frame(BEATS, 2);
        go_idle();
        check_stream("random", 2 * BEATS);

        // Reset in the middle of a read
        gen_rand();
        drive_frame(BEATS, 0);
        go_idle();
        for (int t = 0; t < 200 && cap_r.size() < 10; t++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("midread_valid", W'(bus.dout_valid), W'(1));
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", W'(bus.dout_valid), W'(0));
        check("midrst_sof", W'(bus.dout_sof), W'(0));
        check("midrst_re", pack_out(1'b0), W'(0));
        check("midrst_im", pack_out(1'b1), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
        gen_rand();
        drive_frame(BEATS, 0);
        go_idle();
        check_stream("after_rst", BEATS);

        // Partial frame then idle: nothing comes out
        gen_rand();
        drive_frame(20, 0);
        go_idle();
        repeat (100) @(negedge clk);
        check_stream("partial", 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gen_rand();
        drive_frame(BEATS, 0);
        go_idle();
        check_stream("post_partial", BEATS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
